// File: rtl/ysyx_23060278_mdu_pkg.sv
// rtl/ysyx_23060278_mdu_pkg.sv - op encodings, FSM states and operand-sign helpers for the MDU
package ysyx_23060278_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // rs1 is treated as two's complement for mulh, mulhsu, div and rem
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as two's complement for mulh, div and rem (mulhsu keeps it unsigned)
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/ysyx_23060278_divider.sv
// rtl/ysyx_23060278_divider.sv - restoring radix-2 unsigned divider, one quotient bit per cycle
module ysyx_23060278_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic            run_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // partial remainder shifted left by one dividend bit; the top bit of diff is the borrow
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  // one restoring step per cycle until the counter drains; kill abandons the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (kill) begin
      run_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(XLEN);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (run_q && (cnt_q != '0)) begin
      rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ysyx_23060278_mdu.sv
// rtl/ysyx_23060278_mdu.sv - multi-cycle RV32M/RV64M multiply-divide unit, one op in flight
module ysyx_23060278_mdu
  import ysyx_23060278_mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic             spec_q;
  logic [MCW-1:0]   mcnt_q;

  logic             accept;
  logic             in_b_zero, in_ovf, in_spec;
  logic [XLEN-1:0]  spec_res;
  logic             in_neg_a, in_neg_b;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             div_start, div_done, div_kill;
  logic [XLEN-1:0]  div_quo, div_rem;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0]  mul_res, div_res;
  logic             q_neg, r_neg;

  // flush wins over a same-cycle request, so the op is never latched
  assign accept = in_valid && in_ready && !flush;

  // divide-by-zero and signed overflow are resolved up front instead of running the divider
  assign in_b_zero = (in_b == '0);
  assign in_ovf    = is_signed_a(in_op) && in_op[2] && (in_a == INT_MIN) && (&in_b);
  assign in_spec   = in_op[2] && (in_b_zero || in_ovf);
  assign spec_res  = in_b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);

  // the divider works on magnitudes; signs are reapplied from the latched operands
  assign in_neg_a  = is_signed_a(in_op) && in_a[XLEN-1];
  assign in_neg_b  = is_signed_b(in_op) && in_b[XLEN-1];
  assign mag_a     = in_neg_a ? -in_a : in_a;
  assign mag_b     = in_neg_b ? -in_b : in_b;
  assign div_start = accept && in_op[2] && !in_spec;
  assign div_kill  = flush || ((state_q == S_DIV) && div_done);

  ysyx_23060278_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .kill      (div_kill),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // full-width product of the sign- or zero-extended operands; truncation keeps it exact
  assign ext_a   = is_signed_a(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign ext_b   = is_signed_b(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod    = ext_a * ext_b;
  assign mul_res = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // quotient negated when operand signs differ, remainder follows the dividend
  assign q_neg   = is_signed_a(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg   = is_signed_a(op_q) && a_q[XLEN-1];
  assign div_res = op_q[1] ? (r_neg ? -div_rem : div_rem) : (q_neg ? -div_quo : div_quo);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; flush overrides every transition including a pending out handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = in_op[2] ? S_DIV : S_MUL;
      S_MUL:  if (mcnt_q == '0) state_d = S_DONE;
      S_DIV:  if (spec_q || div_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // operand capture at accept, multiply countdown and result capture on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      res_q  <= '0;
      spec_q <= 1'b0;
      mcnt_q <= '0;
    end else if (accept) begin
      op_q   <= in_op;
      a_q    <= in_a;
      b_q    <= in_b;
      tag_q  <= in_tag;
      spec_q <= in_spec;
      mcnt_q <= MCW'(MUL_LAT - 1);
      if (in_spec) res_q <= spec_res;
    end else if (!flush) begin
      if (state_q == S_MUL) begin
        if (mcnt_q == '0) res_q  <= mul_res;
        else              mcnt_q <= mcnt_q - MCW'(1);
      end
      if ((state_q == S_DIV) && div_done && !spec_q) res_q <= div_res;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_ysyx_23060278_mdu.sv
// tb/tb_ysyx_23060278_mdu.sv - scoreboard bench for the multiply-divide unit
module tb_ysyx_23060278_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  ysyx_23060278_mdu #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fv_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor: records the first out_valid cycle and scores every output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_v) fv_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got result %h tag %h with nothing outstanding", out_result, out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", out_result, e.res);
          chk("tag", {27'd0, out_tag}, {27'd0, e.tag});
          chk("latency", 32'(fv_cyc - e.acc), 32'(e.lat));
        end
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive one request; when push is set the expected response goes to the scoreboard
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat, input bit push);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.res = res;
    e.tag = tag;
    e.lat = lat;
    e.acc = cyc;
    if (push) exp_q.push_back(e);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // multiplies
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, 1'b1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 2, 1'b1);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 2, 1'b1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 2, 1'b1);
    issue(3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 5'd5, 32'hFFFF_FFFF, 2, 1'b1);

    // divides
    issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 32'hFFFF_FFFD, 33, 1'b1);
    issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 32'hFFFF_FFFF, 33, 1'b1);
    issue(3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 33, 1'b1);
    issue(3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 33, 1'b1);
    issue(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, 33, 1'b1);

    // special cases, single-cycle latency
    issue(3'b101, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, 1'b1);
    issue(3'b111, 32'd5, 32'd0, 5'd12, 32'd5, 1, 1'b1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, 1'b1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1, 1'b1);

    // output back-pressure: result and tag must hold while the consumer stalls
    while (!in_ready) step(1);
    out_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd5, 5'd15, 32'd15, 2, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        step(1);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stall_result", out_result, 32'd15);
    end
    chk("stall_tag", {27'd0, out_tag}, 32'd15);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step(1);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);

    // flush in the middle of a divide: dropped, then the unit takes new work
    issue(3'b101, 32'd1000, 32'd3, 5'd16, 32'd0, 0, 1'b0);
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step(40);
    issue(3'b101, 32'd1000, 32'd3, 5'd17, 32'd333, 33, 1'b1);

    // asynchronous reset in the middle of a divide
    issue(3'b100, 32'd77, 32'd5, 5'd18, 32'd0, 0, 1'b0);
    step(5);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out_result", out_result, 32'd0);
    chk("arst_out_tag", {27'd0, out_tag}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(40);
    issue(3'b110, 32'd77, 32'd5, 5'd19, 32'd2, 33, 1'b1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        step(1);
        n++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
      end
    end
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
